// File: rtl/prog_loader.sv
// Program-memory loader: parses a LEN / data words / CSUM byte frame, writes
// 16-bit words into program RAM and holds the core in reset until the frame verifies.
module prog_loader #(
    parameter int PC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    output logic                we,
    output logic [PC_WIDTH-1:0] waddr,
    output logic [15:0]         wdata,
    output logic                core_reset,
    output logic                done,
    output logic                error
);
    localparam int DEPTH = 1 << PC_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LO,
        S_HI,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH:0]   n_q, n_d;
    logic [PC_WIDTH:0]   idx_q, idx_d;
    logic [PC_WIDTH:0]   idx_inc;
    logic [7:0]          sum_q, sum_d;
    logic [7:0]          lo_q, lo_d;
    logic                we_q, we_d;
    logic [PC_WIDTH-1:0] waddr_q, waddr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                xfer;
    logic                len_bad;

    assign byte_ready = (state_q == S_LEN) || (state_q == S_LO) ||
                        (state_q == S_HI)  || (state_q == S_CSUM);
    assign xfer       = byte_valid && byte_ready;
    assign idx_inc    = idx_q + (PC_WIDTH+1)'(1);
    assign len_bad    = (byte_data == 8'd0) || ({1'b0, byte_data} > 9'(DEPTH));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN;
            end
            S_LEN: begin
                if (xfer) begin
                    if (len_bad) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = byte_data[PC_WIDTH:0];
                        idx_d   = '0;
                        sum_d   = 8'd0;
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = byte_data;
                    sum_d   = sum_q + byte_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                // Word is registered here and appears on the RAM port next cycle.
                if (xfer) begin
                    sum_d   = sum_q + byte_data;
                    we_d    = 1'b1;
                    waddr_d = idx_q[PC_WIDTH-1:0];
                    wdata_d = {byte_data, lo_q};
                    idx_d   = idx_inc;
                    state_d = (idx_inc == n_q) ? S_CSUM : S_LO;
                end
            end
            S_CSUM: begin
                if (xfer) state_d = (byte_data == sum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            sum_q   <= 8'd0;
            lo_q    <= 8'd0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign core_reset = (state_q != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames with hand-computed words and checksums.
module tb_prog_loader;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset, start, byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready, we, core_reset, done, error;
    logic [PW-1:0] waddr;
    logic [15:0]   wdata;

    int err_cnt = 0;
    int chk_cnt = 0;
    int wr_cnt  = 0;
    int xfer_cnt = 0;
    logic [PW-1:0] wr_addr [0:63];
    logic [15:0]   wr_data [0:63];

    prog_loader #(.PC_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .we(we), .waddr(waddr),
        .wdata(wdata), .core_reset(core_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we && wr_cnt < 64) begin
            wr_addr[wr_cnt] = waddr;
            wr_data[wr_cnt] = wdata;
        end
        if (we) wr_cnt++;
        if (byte_valid && byte_ready) xfer_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Holds the byte until accepted; gap>0 inserts idle cycles with valid low first.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   k;
        if (gap > 0) begin
            byte_valid = 1'b0;
            tick(gap);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        k = 0;
        rdy = 1'b0;
        while (!rdy && k < 20) begin
            @(negedge clk);
            rdy = byte_ready;
            tick(1);
            k++;
        end
        byte_valid = 1'b0;
        if (!rdy) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame1(input logic [7:0] csum, input bit gaps);
        logic [7:0] f [0:5];
        f[0] = 8'h02; f[1] = 8'h34; f[2] = 8'h12; f[3] = 8'h78; f[4] = 8'h56; f[5] = csum;
        for (int i = 0; i < 6; i++) send_byte(f[i], gaps ? int'($urandom_range(0, 3)) : 0);
        tick(2);
    endtask

    task automatic clear_log();
        wr_cnt = 0;
        xfer_cnt = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        tick(3);
        chk("rst_ready", byte_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;
        tick(1);
        chk("idle_ready", byte_ready, 0);

        // 1: good two-word frame
        clear_log();
        pulse_start();
        chk("len_ready", byte_ready, 1);
        send_frame1(8'h14, 1'b0);
        chk("t1_wr_cnt", wr_cnt, 2);
        chk("t1_a0", wr_addr[0], 0);
        chk("t1_d0", wr_data[0], 16'h1234);
        chk("t1_a1", wr_addr[1], 1);
        chk("t1_d1", wr_data[1], 16'h5678);
        chk("t1_done", done, 1);
        chk("t1_error", error, 0);
        chk("t1_core_reset", core_reset, 0);
        chk("t1_ready", byte_ready, 0);
        chk("t1_hold_waddr", waddr, 1);
        chk("t1_hold_wdata", wdata, 16'h5678);
        chk("t1_we_idle", we, 0);
        // valid while not ready must not be consumed
        xfer_cnt = 0;
        byte_valid = 1'b1; byte_data = 8'h02;
        tick(3);
        byte_valid = 1'b0;
        chk("done_no_xfer", xfer_cnt, 0);
        chk("done_stays", done, 1);

        // 2: bad checksum
        clear_log();
        pulse_start();
        chk("restart_done_clr", done, 0);
        chk("restart_core_reset", core_reset, 1);
        send_frame1(8'h15, 1'b0);
        chk("t2_wr_cnt", wr_cnt, 2);
        chk("t2_d1", wr_data[1], 16'h5678);
        chk("t2_error", error, 1);
        chk("t2_done", done, 0);
        chk("t2_core_reset", core_reset, 1);

        // 3: illegal lengths
        clear_log();
        pulse_start();
        chk("t3_err_clr", error, 0);
        send_byte(8'h00, 0);
        tick(1);
        chk("t3_len0_err", error, 1);
        pulse_start();
        send_byte(8'h11, 0);
        tick(1);
        chk("t3_len17_err", error, 1);
        chk("t3_no_we", wr_cnt, 0);
        chk("t3_ready", byte_ready, 0);

        // 4: full-depth frame of 0xFF
        clear_log();
        pulse_start();
        send_byte(8'h10, 0);
        for (int i = 0; i < 32; i++) send_byte(8'hFF, 0);
        send_byte(8'hE0, 0);
        tick(2);
        chk("t4_wr_cnt", wr_cnt, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4_a%0d", i), wr_addr[i], i);
            chk($sformatf("t4_d%0d", i), wr_data[i], 16'hFFFF);
        end
        chk("t4_done", done, 1);

        // 5: frame 1 with random valid gaps and a stray start mid-frame
        clear_log();
        pulse_start();
        send_byte(8'h02, 2);
        send_byte(8'h34, 1);
        pulse_start();
        send_byte(8'h12, 3);
        send_byte(8'h78, 0);
        send_byte(8'h56, 2);
        send_byte(8'h14, 1);
        tick(2);
        chk("t5_wr_cnt", wr_cnt, 2);
        chk("t5_d0", wr_data[0], 16'h1234);
        chk("t5_a1", wr_addr[1], 1);
        chk("t5_d1", wr_data[1], 16'h5678);
        chk("t5_xfer", xfer_cnt, 6);
        chk("t5_done", done, 1);
        clear_log();
        pulse_start();
        send_frame1(8'h14, 1'b1);
        chk("t5r_wr_cnt", wr_cnt, 2);
        chk("t5r_d1", wr_data[1], 16'h5678);
        chk("t5r_done", done, 1);

        // 6: reset after first word
        clear_log();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        tick(1);
        chk("t6_first_wr", wr_cnt, 1);
        reset = 1'b1;
        tick(1);
        chk("t6_we", we, 0);
        chk("t6_waddr", waddr, 0);
        chk("t6_wdata", wdata, 0);
        chk("t6_ready", byte_ready, 0);
        chk("t6_core_reset", core_reset, 1);
        chk("t6_done", done, 0);
        chk("t6_error", error, 0);
        reset = 1'b0;
        tick(1);
        clear_log();
        pulse_start();
        send_frame1(8'h14, 1'b0);
        chk("t6_wr_cnt", wr_cnt, 2);
        chk("t6_d0", wr_data[0], 16'h1234);
        chk("t6_d1", wr_data[1], 16'h5678);
        chk("t6_done2", done, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
